// File: rtl/print_sequencer.sv
// -----------------------------------------------------------------------------
// print_sequencer
//
// Walks the UART printer through NUM_STR consecutive string IDs. Each string
// gets exactly one single-cycle printer_enable pulse, after which the block
// waits for printer_done before launching the next string. Once the last
// string completes the block parks in DONE. If a per-string watchdog is
// configured and the printer never answers, the block parks in ERROR.
// Either parked state is left again by a trigger, which restarts at index 0.
//
// Ports
//   clk            : system clock, all logic on the rising edge
//   rst            : synchronous active-high reset
//   trigger        : level-sampled start / restart request
//   printer_done   : printer finished the current string
//   printer_enable : one-cycle start pulse to the printer
//   printer_str_id : string ID, FIRST_ID + index, stable from pulse to done
//   seq_state      : state code (IDLE=0, LAUNCH=1, WAIT=2, DONE=3, ERROR=4)
//   seq_index      : 0-based index of the current string
//   seq_done       : high while parked in DONE
//   seq_error      : high while parked in ERROR
// -----------------------------------------------------------------------------
module print_sequencer #(
  parameter int NUM_STR        = 4,
  parameter int ID_W           = 4,
  parameter int FIRST_ID       = 0,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int AUTO_START     = 1,
  localparam int IDX_W = (NUM_STR > 1) ? $clog2(NUM_STR) : 1,
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trigger,
  input  logic             printer_done,
  output logic             printer_enable,
  output logic [ID_W-1:0]  printer_str_id,
  output logic [2:0]       seq_state,
  output logic [IDX_W-1:0] seq_index,
  output logic             seq_done,
  output logic             seq_error
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_DONE   = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_STR - 1);
  // With the watchdog disabled this value is never compared (guarded below).
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  index_q, index_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              auto_pending_q, auto_pending_d;

  // State, index, watchdog count and the one-shot auto-start request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      index_q        <= '0;
      count_q        <= '0;
      auto_pending_q <= (AUTO_START != 0);
    end else begin
      state_q        <= state_d;
      index_q        <= index_d;
      count_q        <= count_d;
      auto_pending_q <= auto_pending_d;
    end
  end

  // Next-state logic. printer_done is deliberately not looked at in LAUNCH:
  // a completion still asserted from the previous string must not skip the
  // string that is only now being started. Trigger is ignored while a
  // sequence is in flight; there is no queuing of restart requests.
  always_comb begin
    state_d        = state_q;
    index_d        = index_q;
    count_d        = count_q;
    auto_pending_d = auto_pending_q;
    case (state_q)
      S_IDLE: begin
        if (trigger || auto_pending_q) begin
          state_d        = S_LAUNCH;
          index_d        = '0;
          auto_pending_d = 1'b0;
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT;
        count_d = '0;
      end
      S_WAIT: begin
        // A completion on the final watchdog cycle still counts as success.
        if (printer_done) begin
          if (index_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            index_d = index_q + IDX_W'(1);
            state_d = S_LAUNCH;
          end
        end else if ((TIMEOUT_CYCLES != 0) && (count_q == CNT_LIMIT)) begin
          state_d = S_ERROR;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      S_DONE, S_ERROR: begin
        if (trigger) begin
          state_d = S_LAUNCH;
          index_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign printer_enable = (state_q == S_LAUNCH);
  assign printer_str_id = ID_W'(FIRST_ID + int'(index_q));
  assign seq_state      = state_q;
  assign seq_index      = index_q;
  assign seq_done       = (state_q == S_DONE);
  assign seq_error      = (state_q == S_ERROR);

endmodule
